// File: rtl/risc_toy_sysctl.sv
// risc_toy_sysctl
// System-control responder on the RISC_TOY_CORE data-memory bus. A running
// program uses a small MMIO window to report its exit status, write console
// bytes, and read a free-running 64-bit cycle counter. An optional watchdog
// halts the run if the program never reports.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   bus_req/we/addr/wdata    single-cycle bus access, always accepted
//   bus_hit                  combinational: request falls inside the window
//   bus_rvalid/bus_rdata     read response, one cycle after a read hit
//   con_valid/data/ready     console byte FIFO output (valid/ready pop)
//   halted/pass/fail         run status, sticky until reset
//   timeout/exit_code        watchdog indication and latched exit code
module risc_toy_sysctl #(
   parameter int                ADDR_W     = 32,
   parameter int                XLEN       = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'hFFFF_0000),
   parameter int                FIFO_DEPTH = 8,
   parameter logic [63:0]       TIMEOUT    = 64'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_req,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [XLEN-1:0]   bus_wdata,
   output logic              bus_hit,
   output logic              bus_rvalid,
   output logic [XLEN-1:0]   bus_rdata,
   output logic              con_valid,
   output logic [7:0]        con_data,
   input  logic              con_ready,
   output logic              halted,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [XLEN-2:0]   exit_code
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [63:0]      cnt_q, cnt_d;
   logic [31:0]      hi_shadow_q, hi_shadow_d;
   logic             rvalid_q, rvalid_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             timeout_q, timeout_d;
   logic [XLEN-2:0]  exit_q, exit_d;
   logic [7:0]       mem_q [FIFO_DEPTH];

   logic [ADDR_W-1:0] offset;
   logic [2:0]        reg_sel;
   logic              run;
   logic              tohost_exit;
   logic              wdog_fire;
   logic              push_req;
   logic              push;
   logic              pop;
   logic              full;
   logic [XLEN-1:0]   status;

   // An address below the base wraps to a huge offset, so one unsigned
   // compare covers both ends of the window.
   assign offset  = bus_addr - BASE_ADDR;
   assign reg_sel = offset[4:2];
   assign bus_hit = bus_req && (offset < ADDR_W'(20));
   assign run     = (state_q == ST_RUN);

   assign con_valid = (count_q != '0);
   assign con_data  = con_valid ? mem_q[rd_ptr_q] : 8'h00;

   always_comb begin
      status     = '0;
      status[16] = overflow_q;
      status[15:8] = 8'(count_q);
      status[2]  = timeout_q;
      status[1]  = (state_q == ST_HALTED);
      status[0]  = con_valid;
   end

   // Next-state logic: bus decode, FIFO bookkeeping, counter and halt control.
   // A pop in the same cycle frees a slot, so a push into a full FIFO is only
   // dropped when nothing is leaving.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_shadow_d = hi_shadow_q;
      rvalid_d    = 1'b0;
      rdata_d     = '0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      timeout_d   = timeout_q;
      exit_d      = exit_q;

      tohost_exit = bus_hit && bus_we && (reg_sel == 3'd0) && bus_wdata[0] && run;
      wdog_fire   = (TIMEOUT != 64'd0) && run && (cnt_q == TIMEOUT - 64'd1);
      push_req    = bus_hit && bus_we && (reg_sel == 3'd1) && run;
      pop         = con_valid && con_ready;
      full        = (count_q == CNT_W'(FIFO_DEPTH));
      push        = push_req && (!full || pop);

      if (push_req && !push) begin
         overflow_d = 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (run) begin
         cnt_d = cnt_q + 64'd1;
      end

      // The program's own exit report takes priority over the watchdog.
      if (tohost_exit) begin
         state_d   = ST_HALTED;
         exit_d    = bus_wdata[XLEN-1:1];
         timeout_d = 1'b0;
      end else if (wdog_fire) begin
         state_d   = ST_HALTED;
         exit_d    = '1;
         timeout_d = 1'b1;
      end

      // Reading the low word freezes the high word so a later HI read is
      // consistent with it even if the counter carries in between.
      if (bus_hit && !bus_we) begin
         rvalid_d = 1'b1;
         case (reg_sel)
            3'd2: rdata_d = status;
            3'd3: begin
               rdata_d     = XLEN'(cnt_q[31:0]);
               hi_shadow_d = cnt_q[63:32];
            end
            3'd4:    rdata_d = XLEN'(hi_shadow_q);
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         hi_shadow_q <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
         exit_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_shadow_q <= hi_shadow_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         timeout_q   <= timeout_d;
         exit_q      <= exit_d;
      end
   end

   // FIFO storage needs no reset: occupancy is tracked by the pointers and
   // count, and con_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus_wdata[7:0];
      end
   end

   assign bus_rvalid = rvalid_q;
   assign bus_rdata  = rdata_q;
   assign halted     = (state_q == ST_HALTED);
   assign timeout    = timeout_q;
   assign exit_code  = exit_q;
   assign pass       = halted && (exit_q == '0) && !timeout_q;
   assign fail       = halted && !pass;

`ifdef SIM
   always @(posedge clk) begin
      if (rst_n && bus_hit) begin
         assert (bus_addr[1:0] == 2'b00)
            else $error("risc_toy_sysctl: misaligned access to 0x%08h", bus_addr);
      end
      if (rst_n && con_valid) begin
         assert (!$isunknown(con_ready))
            else $error("risc_toy_sysctl: con_ready is unknown while con_valid");
      end
   end
`endif

endmodule

// File: doc/risc_toy_sysctl.md
Name: risc_toy_sysctl

Overview:
Simulation/system-control responder on the RISC_TOY_CORE data-memory bus. It decodes a small MMIO window where the running program reports its exit status, emits console characters and reads a 64-bit cycle counter. It drives halt/pass/fail/exit_code toward the bench or top level, so program-driven termination replaces a bounded cycle run. It is the target-side end of the harness that drives the core.

Parameters:
ADDR_W, 32, bus address width (matches `ADDR_W)
XLEN, 32, data width (matches `XLEN)
BASE_ADDR, 32'hFFFF_0000, MMIO window base; window is 0x14 bytes
FIFO_DEPTH, 8, console FIFO entries (power of two, >=2)
TIMEOUT, 0, watchdog limit in cycles; 0 disables

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
bus_req  in  1  access request, one cycle per access
bus_we  in  1  1=write, 0=read
bus_addr  in  ADDR_W  byte address, word-aligned
bus_wdata  in  XLEN  write data
bus_hit  out  1  combinational: req && addr in window
bus_rvalid  out  1  read data valid, one cycle after read req hit
bus_rdata  out  XLEN  read data, valid with bus_rvalid, else 0
con_valid  out  1  console FIFO non-empty
con_data  out  8  FIFO head byte
con_ready  in  1  consumer pops when valid&&ready
halted  out  1  program finished (level, sticky)
pass  out  1  halted && exit_code==0 && !timeout
fail  out  1  halted && !pass
timeout  out  1  halted by watchdog
exit_code  out  XLEN-1  exit code latched at halt

Behaviour:
- Reset (rst_n=0 at posedge): state=RUN; cycle counter=0; FIFO empty; overflow=0; exit_code=0. All outputs 0. Reset is honoured from any state; FIFO contents are discarded.
- Bus: always ready, no stall. Writes take effect at the posedge of req. Reads return on the next cycle with bus_rvalid=1.
- Misses (addr outside window) are ignored completely: no rvalid.
- Register map (offset from BASE_ADDR):
  - 0x00 TOHOST (W): if wdata[0]=1 and state=RUN, then exit_code<=wdata[XLEN-1:1] and state<=HALTED. wdata[0]=0 is ignored. Reads return 0.
  - 0x04 CONSOLE (W): push wdata[7:0]. If the FIFO is full (after accounting for a same-cycle pop), drop the byte and set overflow (sticky). Reads return 0.
  - 0x08 STATUS (R): {overflow[bit 16], fifo_count[15:8], timeout[2], state==HALTED[1], con_valid[0]}. Writes ignored.
  - 0x0C CYCLE_LO (R): returns cnt[31:0] and snapshots cnt[63:32] into hi_shadow in the same cycle.
  - 0x10 CYCLE_HI (R): returns hi_shadow.
- Cycle counter: 64-bit. Increments every cycle in RUN and freezes in HALTED. Wraps modulo 2^64.
- State machine: RUN -> HALTED on a TOHOST exit write, or on watchdog (TIMEOUT!=0 && cnt==TIMEOUT-1 at the posedge).
  - A watchdog halt sets timeout=1 and exit_code=all ones.
  - If a TOHOST write and the watchdog fire in the same cycle, TOHOST wins and timeout stays 0.
  - HALTED is absorbing until reset. TOHOST and CONSOLE writes are ignored in HALTED. Reads still work.
  - The FIFO keeps draining in HALTED.
- FIFO:
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push when empty: con_valid rises the next cycle; there is no fall-through.
  - con_data is stable while con_valid && !con_ready.
  - Pointers wrap modulo FIFO_DEPTH; count is range 0..FIFO_DEPTH.
- halted/pass/fail/timeout/exit_code are registered and update the cycle after the causing event.
- Under SIM, ASSERT on: a bus_req hit with bus_addr[1:0]!=0, and con_ready used while X.

Test Plan:
- Reset, 10 idle cycles, read CYCLE_LO -> rdata=9 or 10 per capture cycle (bench computes exactly). halted=0, con_valid=0.
- Write TOHOST=0x1 -> next cycle halted=1, pass=1, exit_code=0. Counter frozen on two later reads. A further TOHOST=0x7 is ignored.
- Write TOHOST=0x7 -> fail=1, exit_code=3, timeout=0.
- con_ready=0, push 10 bytes 0x41..0x4A with FIFO_DEPTH=8 -> STATUS count=8, overflow=1. Then con_ready=1 drains exactly 0x41..0x48 in order, and con_valid drops.
- TIMEOUT=20, no writes -> halted at cycle 20 with timeout=1, fail=1, exit_code=all ones. Repeat with TOHOST=0x1 written in the firing cycle -> pass=1, timeout=0.
- Preload cnt near 2^32 (force), read LO then HI -> HI matches the snapshot even if the counter crosses 2^32 between the two reads. Assert rst_n mid-drain -> FIFO empty and all outputs 0 next cycle.
